mn_cmd_encoder: RTL and testbench

//   Transmit side of the M/N flip-flop command interface. Accepts a parallel

---
 rtl/mn_cmd_encoder.sv | 117 +++++++++++
 tb/tb_mn_cmd_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mn_cmd_encoder.sv
// Purpose : serialise a parallel word into per-cycle {M,N} commands for an M/N flip-flop.
// Latency : accept at edge k; bit i's command registered at edge k+1+i; done at edge k+WIDTH+1.
// Backpressure: in_ready low while a word is being sent; next word can be taken in the done cycle.
//
// Ports:
//   clk       clock, all state updates on posedge
//   CLRn      synchronous active-low reset (shared with the downstream M/N flop)
//   in_valid  word available on in_data
//   in_data   word to transmit (WIDTH bits)
//   in_ready  word accepted at an edge where in_valid && in_ready
//   M, N      registered command bits: 00 toggle, 01 set, 10 clear, 11 hold
//   busy      high while a word is being serialised
//   done      one-cycle pulse after the last command of a word
//   nflips    number of non-hold commands of the last word (held between words)
//   q_model   predicted downstream q after the last issued command
module mn_cmd_encoder #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          USE_TOGGLE = 1'b1,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                       clk,
  input  logic                       CLRn,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       M,
  output logic                       N,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] nflips,
  output logic                       q_model
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [CW-1:0]  flips, flips_nxt;
  logic [CW-1:0]  nflips_nxt;
  logic [1:0]     mn_nxt;
  logic           q_nxt;
  logic           done_nxt;
  logic           bit_cur;

  always_ff @(posedge clk) begin
    if (!CLRn) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      flips   <= '0;
      M       <= 1'b1;
      N       <= 1'b1;
      q_model <= 1'b0;
      done    <= 1'b0;
      nflips  <= '0;
    end else begin
      state   <= state_nxt;
      sh      <= sh_nxt;
      cnt     <= cnt_nxt;
      flips   <= flips_nxt;
      M       <= mn_nxt[1];
      N       <= mn_nxt[0];
      q_model <= q_nxt;
      done    <= done_nxt;
      nflips  <= nflips_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh;
    cnt_nxt    = cnt;
    flips_nxt  = flips;
    nflips_nxt = nflips;
    mn_nxt     = 2'b11;
    q_nxt      = q_model;
    done_nxt   = 1'b0;
    // in_ready must drop while reset is held, even though state is already IDLE.
    in_ready   = CLRn && (state == IDLE);
    busy       = (state == SEND);
    // The next bit to send always sits at the outgoing end of the shift register.
    bit_cur    = MSB_FIRST ? sh[WIDTH-1] : sh[0];

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          sh_nxt    = in_data;
          cnt_nxt   = '0;
          flips_nxt = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (cnt < LAST) begin
          if (bit_cur != q_model) begin
            // set is 01 and clear is 10, i.e. {~b, b}
            mn_nxt    = USE_TOGGLE ? 2'b00 : {~bit_cur, bit_cur};
            flips_nxt = flips + 1'b1;
          end
          q_nxt   = bit_cur;
          sh_nxt  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
          cnt_nxt = cnt + 1'b1;
        end else begin
          done_nxt   = 1'b1;
          nflips_nxt = flips;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mn_cmd_encoder.sv
// Purpose : bench for mn_cmd_encoder, three configurations side by side.
// Latency : n/a
// Backpressure: n/a
module tb_mn_cmd_encoder;

  localparam int WIDTH = 8;

  logic       clk;
  logic       CLRn;
  logic       in_valid [3];
  logic [7:0] in_data  [3];
  logic       in_ready [3];
  logic       M        [3];
  logic       N        [3];
  logic       busy     [3];
  logic       done     [3];
  logic [3:0] nflips   [3];
  logic       q_model  [3];

  // u0: toggle, MSB first; u1: set/clear, MSB first; u2: toggle, LSB first
  mn_cmd_encoder #(.WIDTH(8), .USE_TOGGLE(1'b1), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .CLRn(CLRn), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .M(M[0]), .N(N[0]), .busy(busy[0]), .done(done[0]),
    .nflips(nflips[0]), .q_model(q_model[0]));
  mn_cmd_encoder #(.WIDTH(8), .USE_TOGGLE(1'b0), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .CLRn(CLRn), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .M(M[1]), .N(N[1]), .busy(busy[1]), .done(done[1]),
    .nflips(nflips[1]), .q_model(q_model[1]));
  mn_cmd_encoder #(.WIDTH(8), .USE_TOGGLE(1'b1), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .CLRn(CLRn), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .M(M[2]), .N(N[2]), .busy(busy[2]), .done(done[2]),
    .nflips(nflips[2]), .q_model(q_model[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mn;
    logic       busy;
    logic       done;
    logic [3:0] nfl;
    logic       qm;
  } ent_t;

  typedef struct packed {
    logic [1:0]  inst;
    logic [7:0]  data;
    logic [15:0] cmds;   // first command in [15:14]
    logic [3:0]  nfl;
    logic        q;
    logic [7:0]  qseq;   // downstream q after each command, first in [7]
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  ent_t sched [3][10];
  int   rem [3];
  int   pos [3];
  ent_t cur [3];
  logic dq [3];
  int   last_acc [3];
  int   n_acc [3];
  int   n_done [3];
  bit   gapchk = 1'b0;
  vec_t vecs [4];

  function automatic bit tog(input int i);
    return i != 1;
  endfunction

  function automatic bit msb(input int i);
    return i != 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Whole-word expectation: one accept cycle, WIDTH command cycles, one done cycle.
  task automatic plan(input int i, input logic [7:0] d);
    logic       q;
    logic       b;
    logic [1:0] mn;
    int         fl;
    q  = cur[i].qm;
    fl = 0;
    sched[i][0] = {2'b11, 1'b1, 1'b0, cur[i].nfl, q};
    for (int k = 0; k < WIDTH; k++) begin
      b = msb(i) ? d[WIDTH-1-k] : d[k];
      if (b == q)      mn = 2'b11;
      else if (tog(i)) mn = 2'b00;
      else             mn = b ? 2'b01 : 2'b10;
      if (mn != 2'b11) fl++;
      q = b;
      sched[i][k+1] = {mn, 1'b1, 1'b0, cur[i].nfl, q};
    end
    sched[i][WIDTH+1] = {2'b11, 1'b0, 1'b1, 4'(fl), q};
  endtask

  // One clock: predict from the driven inputs, let the edge happen, check at the negedge.
  task automatic tick();
    logic acc_dut;
    logic acc_mod;
    #1;
    for (int i = 0; i < 3; i++) begin
      acc_dut = in_valid[i] && in_ready[i];
      acc_mod = 1'b0;
      if (!CLRn) begin
        rem[i] = 0;
        cur[i] = {2'b11, 1'b0, 1'b0, 4'd0, 1'b0};
      end else if (rem[i] > 0) begin
        cur[i] = sched[i][pos[i]];
        pos[i]++;
        rem[i]--;
      end else if (in_valid[i]) begin
        plan(i, in_data[i]);
        cur[i] = sched[i][0];
        pos[i] = 1;
        rem[i] = WIDTH + 1;
        acc_mod = 1'b1;
      end else begin
        cur[i].mn   = 2'b11;
        cur[i].busy = 1'b0;
        cur[i].done = 1'b0;
      end
      chk($sformatf("u%0d accept", i), 32'(acc_dut), 32'(acc_mod));
      if (acc_dut === 1'b1) begin
        if (gapchk && last_acc[i] >= 0)
          chk($sformatf("u%0d accept_gap", i), 32'(cyc - last_acc[i]), 32'd10);
        last_acc[i] = cyc;
        n_acc[i]++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!CLRn) dq[i] = 1'b0;
      else case ({M[i], N[i]})
        2'b00:   dq[i] = ~dq[i];
        2'b01:   dq[i] = 1'b1;
        2'b10:   dq[i] = 1'b0;
        default: dq[i] = dq[i];
      endcase
      chk($sformatf("u%0d mn", i),      32'({M[i], N[i]}), 32'(cur[i].mn));
      chk($sformatf("u%0d busy", i),    32'(busy[i]),      32'(cur[i].busy));
      chk($sformatf("u%0d done", i),    32'(done[i]),      32'(cur[i].done));
      chk($sformatf("u%0d nflips", i),  32'(nflips[i]),    32'(cur[i].nfl));
      chk($sformatf("u%0d q_model", i), 32'(q_model[i]),   32'(cur[i].qm));
      chk($sformatf("u%0d in_ready", i), 32'(in_ready[i]), 32'(CLRn && rem[i] == 0));
      chk($sformatf("u%0d downstream_q", i), 32'(dq[i]),   32'(cur[i].qm));
      if (done[i] === 1'b1) n_done[i]++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          i;
    logic [15:0] got;
    logic [7:0]  dseq;
    i = int'(v.inst);
    in_valid[i] = 1'b1;
    in_data[i]  = v.data;
    tick();
    in_valid[i] = 1'b0;
    in_data[i]  = 8'($urandom);
    got  = '0;
    dseq = '0;
    for (int k = 0; k < WIDTH; k++) begin
      tick();
      got  = {got[13:0], M[i], N[i]};
      dseq = {dseq[6:0], dq[i]};
    end
    tick();
    chk($sformatf("vec u%0d %0h done", i, v.data),   32'(done[i]),    32'd1);
    chk($sformatf("vec u%0d %0h cmds", i, v.data),   32'(got),        32'(v.cmds));
    chk($sformatf("vec u%0d %0h nflips", i, v.data), 32'(nflips[i]),  32'(v.nfl));
    chk($sformatf("vec u%0d %0h q_model", i, v.data), 32'(q_model[i]), 32'(v.q));
    chk($sformatf("vec u%0d %0h q_seq", i, v.data),  32'(dseq),       32'(v.qseq));
  endtask

  initial begin
    // inst, data, commands, nflips, final q, downstream q sequence
    vecs[0] = {2'd0, 8'hA5, 16'h00C0, 4'd7, 1'b1, 8'hA5};
    vecs[1] = {2'd1, 8'h01, 16'hFFFD, 4'd1, 1'b1, 8'h01};
    vecs[2] = {2'd1, 8'hF0, 16'hFFBF, 4'd1, 1'b0, 8'hF0};
    vecs[3] = {2'd2, 8'h01, 16'h0FFF, 4'd2, 1'b0, 8'h80};

    for (int i = 0; i < 3; i++) begin
      rem[i]      = 0;
      pos[i]      = 0;
      cur[i]      = {2'b11, 1'b0, 1'b0, 4'd0, 1'b0};
      dq[i]       = 1'b0;
      last_acc[i] = -1;
      n_acc[i]    = 0;
      n_done[i]   = 0;
      in_valid[i] = 1'b1;
      in_data[i]  = 8'($urandom);
    end

    // Reset held two cycles with in_valid asserted.
    CLRn = 1'b0;
    tick();
    tick();
    chk("reset mn", 32'({M[0], N[0]}), 32'd3);
    chk("reset in_ready", 32'(in_ready[0]), 32'd0);
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    CLRn = 1'b1;
    tick();
    chk("release in_ready", 32'(in_ready[0] && in_ready[1] && in_ready[2]), 32'd1);

    // Directed words.
    for (int v = 0; v < 4; v++) run_vec(vecs[v]);
    tick();

    // Reset after the third command of a word.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h3C;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    CLRn = 1'b0;
    tick();
    chk("abort mn", 32'({M[0], N[0]}), 32'd3);
    chk("abort done", 32'(done[0]), 32'd0);
    chk("abort q_model", 32'(q_model[0]), 32'd0);
    CLRn = 1'b1;
    tick();
    tick();
    run_vec(vecs[0]);
    tick();

    // in_valid held high with fresh data every cycle.
    gapchk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      last_acc[i] = -1;
      n_acc[i]    = 0;
      n_done[i]   = 0;
      in_valid[i] = 1'b1;
    end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++) in_data[i] = 8'($urandom);
      tick();
    end
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d stream words", i), 32'(n_acc[i]), 32'd30);
      chk($sformatf("u%0d stream dones", i), 32'(n_done[i]), 32'(n_acc[i]));
    end
    gapchk = 1'b0;

    // Sparse random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      CLRn = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = ($urandom_range(0, 2) == 0);
        in_data[i]  = 8'($urandom);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
